// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline types: register address width, writeback tag width
// and the decoded-instruction entry held by the ID issue queue.
package riscv_pkg;

   localparam int REG_ADDR_W      = 5;
   localparam int NUM_REGS        = 1 << REG_ADDR_W;
   localparam int TAG_WIDTH       = 4;
   localparam int ISSUE_PAYLOAD_W = 128;
   localparam int ISSUE_NUM_SRC   = 2;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;

   // One decoded instruction waiting for issue; source i sits at src_addr[5i+4:5i].
   typedef struct packed {
      logic [ISSUE_PAYLOAD_W-1:0]             payload;
      logic [31:0]                            pc;
      logic [ISSUE_NUM_SRC-1:0]               src_en;
      logic [ISSUE_NUM_SRC*REG_ADDR_W-1:0]    src_addr;
      logic                                   rd_en;
      reg_addr_t                              rd_addr;
      logic                                   exc;
      logic [4:0]                             exc_cause;
   } issue_entry_t;

   function automatic reg_addr_t src_addr_of(
      input logic [ISSUE_NUM_SRC*REG_ADDR_W-1:0] addrs,
      input int                                  idx
   );
      return addrs[idx*REG_ADDR_W +: REG_ADDR_W];
   endfunction

endpackage

// File: rtl/id_issue_scoreboard.sv
// Register busy scoreboard: per-register busy bit and writeback tag, a wrapping
// tag allocator, source readiness (with same-cycle clear bypass) and wb clear.
module id_issue_scoreboard
   import riscv_pkg::*;
#(
   parameter int NUM_SRC   = riscv_pkg::ISSUE_NUM_SRC,
   parameter int TAG_WIDTH = riscv_pkg::TAG_WIDTH
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [NUM_SRC-1:0]             src_en,
   input  logic [NUM_SRC*REG_ADDR_W-1:0]  src_addr,
   output logic                           srcs_ready,
   input  logic                           set_en,
   input  logic [REG_ADDR_W-1:0]          set_addr,
   output logic [TAG_WIDTH-1:0]           alloc_tag,
   input  logic                           wb_clr_en,
   input  logic [REG_ADDR_W-1:0]          wb_clr_addr,
   input  logic [TAG_WIDTH-1:0]           wb_clr_tag
);

   logic [NUM_REGS-1:0]  busy;
   logic [TAG_WIDTH-1:0] tag_q [NUM_REGS];
   logic [TAG_WIDTH-1:0] tag_ctr;
   logic [NUM_SRC-1:0]   src_ok;

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      reg_addr_t a;
      assign a = src_addr[i*REG_ADDR_W +: REG_ADDR_W];
      // A matching writeback this cycle releases the source without waiting a cycle.
      assign src_ok[i] = !src_en[i] || (a == '0) || !busy[a] ||
                         (wb_clr_en && (wb_clr_addr == a) && (wb_clr_tag == tag_q[a]));
   end

   assign srcs_ready = &src_ok;
   assign alloc_tag  = tag_ctr;

   always_ff @(posedge clk) begin
      if (reset) begin
         busy    <= '0;
         tag_ctr <= '0;
         for (int r = 0; r < NUM_REGS; r++) tag_q[r] <= '0;
      end else begin
         if (wb_clr_en && (wb_clr_tag == tag_q[wb_clr_addr]))
            busy[wb_clr_addr] <= 1'b0;
         // Placed after the clear so a new allocation on the same register wins.
         if (set_en && (set_addr != '0)) begin
            busy[set_addr]  <= 1'b1;
            tag_q[set_addr] <= tag_ctr;
            tag_ctr         <= tag_ctr + TAG_WIDTH'(1);
         end
      end
   end

endmodule

// File: rtl/id_issue_queue.sv
// In-order issue queue between decode and EX with register hazard tracking.
// Optional ID_ISSUE_BYPASS_EN: an empty queue presents the incoming instruction directly.
module id_issue_queue
   import riscv_pkg::*;
#(
   parameter int DEPTH     = 4,
   parameter int PAYLOAD_W = riscv_pkg::ISSUE_PAYLOAD_W,
   parameter int NUM_SRC   = riscv_pkg::ISSUE_NUM_SRC,
   parameter int TAG_WIDTH = riscv_pkg::TAG_WIDTH
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          flush,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [PAYLOAD_W-1:0]          in_payload,
   input  logic [31:0]                   in_pc,
   input  logic [NUM_SRC-1:0]            in_src_en,
   input  logic [NUM_SRC*5-1:0]          in_src_addr,
   input  logic                          in_rd_en,
   input  logic [4:0]                    in_rd_addr,
   input  logic                          in_exc,
   input  logic [4:0]                    in_exc_cause,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [PAYLOAD_W-1:0]          out_payload,
   output logic [31:0]                   out_pc,
   output logic                          out_rd_en,
   output logic [4:0]                    out_rd_addr,
   output logic [TAG_WIDTH-1:0]          out_rd_tag,
   output logic                          out_exc,
   output logic [4:0]                    out_exc_cause,
   input  logic                          wb_clr_en,
   input  logic [4:0]                    wb_clr_addr,
   input  logic [TAG_WIDTH-1:0]          wb_clr_tag,
   output logic                          hazard_stall,
   output logic [$clog2(DEPTH):0]        count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   issue_entry_t       mem [DEPTH];
   logic [PTR_W-1:0]   rd_ptr;
   logic [PTR_W-1:0]   wr_ptr;
   logic [CNT_W-1:0]   cnt_q;
   logic               exc_block;

   issue_entry_t       in_entry;
   issue_entry_t       cand;
   logic               head_valid;
   logic               from_input;
   logic               cand_valid;
   logic               issue_open;
   logic               srcs_ready;
   logic               fire;
   logic               push;
   logic               pop;
   logic               set_en;

   assign in_entry = '{payload:   in_payload,
                       pc:        in_pc,
                       src_en:    in_src_en,
                       src_addr:  in_src_addr,
                       rd_en:     in_rd_en,
                       rd_addr:   in_rd_addr,
                       exc:       in_exc,
                       exc_cause: in_exc_cause};

   assign head_valid = (cnt_q != '0);

`ifdef ID_ISSUE_BYPASS_EN
   assign from_input = !head_valid && in_valid;
`else
   assign from_input = 1'b0;
`endif

   assign cand       = from_input ? in_entry : mem[rd_ptr];
   assign cand_valid = head_valid || from_input;

   id_issue_scoreboard #(
      .NUM_SRC   (NUM_SRC),
      .TAG_WIDTH (TAG_WIDTH)
   ) u_scoreboard (
      .clk         (clk),
      .reset       (reset),
      .src_en      (cand.src_en),
      .src_addr    (cand.src_addr),
      .srcs_ready  (srcs_ready),
      .set_en      (set_en),
      .set_addr    (cand.rd_addr),
      .alloc_tag   (out_rd_tag),
      .wb_clr_en   (wb_clr_en),
      .wb_clr_addr (wb_clr_addr),
      .wb_clr_tag  (wb_clr_tag)
   );

   // Handshakes: a transfer happens on a clock edge where valid and ready are both
   // high. in_ready depends only on occupancy and reset, never on a same-cycle pop;
   // out_valid never depends on out_ready and, once high, the head holds until taken
   // or flushed.
   assign in_ready     = (cnt_q < CNT_W'(DEPTH)) && !reset;
   assign issue_open   = cand_valid && !flush && !exc_block && !reset;
   assign out_valid    = issue_open && (cand.exc || srcs_ready);
   assign hazard_stall = issue_open && !cand.exc && !srcs_ready;

   assign fire   = out_valid && out_ready;
   assign push   = in_valid && in_ready && !flush && !(fire && from_input);
   assign pop    = fire && !from_input;
   assign set_en = fire && cand.rd_en && (cand.rd_addr != '0) && !cand.exc;

   assign out_payload   = cand.payload;
   assign out_pc        = cand.pc;
   assign out_rd_en     = cand.rd_en;
   assign out_rd_addr   = cand.rd_addr;
   assign out_exc       = cand.exc;
   assign out_exc_cause = cand.exc_cause;
   assign count         = cnt_q;

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         cnt_q     <= '0;
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         exc_block <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   cnt_q <= cnt_q + CNT_W'(1);
            2'b01:   cnt_q <= cnt_q - CNT_W'(1);
            default: cnt_q <= cnt_q;
         endcase
         if (fire && cand.exc) exc_block <= 1'b1;
      end
   end

   // Entry storage needs no reset: nothing is read while count is zero.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_entry;
   end

endmodule
